// File: rtl/score_pkg.sv
// ============================================================================
// Module   : score_pkg
// Brief    : Shared types and helpers for the score keeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package score_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD    = 2'd1,
        S_COMMIT = 2'd2
    } add_state_t;

    // Producers may hand us non-decimal nibbles; treat anything above 9 as 9.
    function automatic bcd_t bcd_clamp(bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// ============================================================================
// Module   : bcd_digit_add
// Brief    : Combinational single-digit BCD adder with carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t s,
    output logic cout
);

    logic [4:0] w_bin;
    logic [4:0] w_adj;

    assign w_bin = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign w_adj = w_bin - 5'd10;

    always_comb begin
        s    = w_bin[3:0];
        cout = 1'b0;
        if (w_bin >= 5'd10) begin
            s    = w_adj[3:0];
            cout = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// Module   : score_keeper
// Brief    : Multi-player BCD score accumulator with queued adds, saturation,
//            high-score tracking and extra-life pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper
    import score_pkg::*;
#(
    parameter  int DIGITS      = 4,
    parameter  int PLAYERS     = 2,
    parameter  int QDEPTH      = 4,
    parameter  int BONUS_DIGIT = 3,
    localparam int PW          = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                add_valid,
    output logic                                add_ready,
    input  logic [PW-1:0]                       add_player,
    input  logic [DIGITS-1:0][3:0]              add_value,
    input  logic                                clear,
    output logic [PLAYERS-1:0][DIGITS-1:0][3:0] score,
    output logic [DIGITS-1:0][3:0]              hi_score,
    output logic [PLAYERS-1:0]                  extra_life,
    output logic                                busy
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Pending-add FIFO
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic [PW-1:0]          fifo_player_q [QDEPTH];
    logic [DIGITS-1:0][3:0] fifo_value_q  [QDEPTH];

    // Adder working state; partial sums never touch score_q before COMMIT
    add_state_t             state_q, state_d;
    logic [IW-1:0]          idx_q;
    logic [PW-1:0]          player_q;
    logic [DIGITS-1:0][3:0] val_q;
    logic [DIGITS-1:0][3:0] sum_q;
    logic                   carry_q;

    logic [PLAYERS-1:0][DIGITS-1:0][3:0] score_q;
    logic [DIGITS-1:0][3:0]              hi_q;
    logic [PLAYERS-1:0]                  extra_q;

    logic                   w_full, w_empty, w_push, w_pop, w_commit;
    logic [DIGITS-1:0][3:0] w_cur_score, w_result;
    logic                   w_old_sat, w_bonus;
    logic [PLAYERS-1:0]     w_extra_d;
    bcd_t                   w_s;
    logic                   w_cout;

    assign w_full    = (count_q == CW'(QDEPTH));
    assign w_empty   = (count_q == '0);
    assign add_ready = !w_full;
    // Awards for non-existent players are accepted but never queued.
    assign w_push    = add_valid && add_ready && !clear && (32'(add_player) < PLAYERS);

    assign w_cur_score = score_q[player_q];

    bcd_digit_add u_digit_add (
        .a    (w_cur_score[idx_q]),
        .b    (val_q[idx_q]),
        .cin  (carry_q),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_result  = carry_q ? {DIGITS{4'd9}} : sum_q;
    assign w_old_sat = (w_cur_score == {DIGITS{4'd9}});
    assign w_bonus   = (w_result[DIGITS-1:BONUS_DIGIT] != w_cur_score[DIGITS-1:BONUS_DIGIT])
                       && !w_old_sat;

    always_comb begin
        state_d  = state_q;
        w_pop    = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop   = 1'b1;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (idx_q == IW'(DIGITS - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d  = S_IDLE;
            w_pop    = 1'b0;
            w_commit = 1'b0;
        end
    end

    always_comb begin
        w_extra_d = '0;
        if (w_commit && w_bonus) begin
            w_extra_d[player_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                fifo_player_q[i] <= '0;
                fifo_value_q[i]  <= '0;
            end
            idx_q    <= '0;
            player_q <= '0;
            val_q    <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            score_q  <= '0;
            hi_q     <= '0;
            extra_q  <= '0;
        end else begin
            extra_q <= w_extra_d;
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                score_q  <= '0;
            end else begin
                if (w_push) begin
                    fifo_player_q[wr_ptr_q] <= add_player;
                    fifo_value_q[wr_ptr_q]  <= add_value;
                    wr_ptr_q                <= wr_ptr_q + AW'(1);
                end
                if (w_pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    player_q <= fifo_player_q[rd_ptr_q];
                    for (int d = 0; d < DIGITS; d++) begin
                        val_q[d] <= bcd_clamp(fifo_value_q[rd_ptr_q][d]);
                    end
                    carry_q <= 1'b0;
                    idx_q   <= '0;
                end
                count_q <= count_q + CW'(w_push) - CW'(w_pop);
                if (state_q == S_ADD) begin
                    sum_q[idx_q] <= w_s;
                    carry_q      <= w_cout;
                    idx_q        <= idx_q + IW'(1);
                end
                if (w_commit) begin
                    score_q[player_q] <= w_result;
                    if (w_result > hi_q) begin
                        hi_q <= w_result;
                    end
                end
            end
        end
    end

    assign score      = score_q;
    assign hi_score   = hi_q;
    assign extra_life = extra_q;
    assign busy       = !w_empty || (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_score_keeper.sv
// ============================================================================
// Module   : tb_score_keeper
// Brief    : Directed self-checking bench for score_keeper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_score_keeper;

    logic                  clk;
    logic                  resetN;
    logic                  add_valid;
    logic                  add_ready;
    logic [0:0]            add_player;
    logic [3:0][3:0]       add_value;
    logic                  clear;
    logic [1:0][3:0][3:0]  score;
    logic [3:0][3:0]       hi_score;
    logic [1:0]            extra_life;
    logic                  busy;

    int n_checks = 0;
    int n_pass   = 0;
    int el0_cnt  = 0;
    int el1_cnt  = 0;

    score_keeper #(
        .DIGITS      (4),
        .PLAYERS     (2),
        .QDEPTH      (4),
        .BONUS_DIGIT (3)
    ) u_dut (
        .clk        (clk),
        .resetN     (resetN),
        .add_valid  (add_valid),
        .add_ready  (add_ready),
        .add_player (add_player),
        .add_value  (add_value),
        .clear      (clear),
        .score      (score),
        .hi_score   (hi_score),
        .extra_life (extra_life),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (extra_life[0]) el0_cnt++;
        if (extra_life[1]) el1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input logic p, input logic [15:0] v);
        @(negedge clk);
        add_valid  = 1'b1;
        add_player = p;
        add_value  = v;
        @(negedge clk);
        add_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    logic [15:0] burst_v [8];
    logic        burst_r [8];
    logic [15:0] clr_v   [4];
    int          snap0, snap1;

    initial begin
        resetN     = 1'b0;
        add_valid  = 1'b0;
        add_player = 1'b0;
        add_value  = '0;
        clear      = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        check("rst_score",  score,       32'h0000_0000);
        check("rst_hi",     hi_score,    32'h0000);
        check("rst_extra",  extra_life,  32'd0);
        check("rst_ready",  add_ready,   32'd1);
        check("rst_busy",   busy,        32'd0);

        // Test 1: accumulate on P0, with latency check on the first award
        snap0 = el0_cnt;
        push(1'b0, 16'h0025);
        repeat (5) @(negedge clk);
        check("lat_before", score[0], 32'h0000);
        @(negedge clk);
        check("lat_after",  score[0], 32'h0025);
        wait_idle();
        push(1'b0, 16'h0017);
        wait_idle();
        check("t1_score", score[0], 32'h0042);
        check("t1_hi",    hi_score, 32'h0042);
        push(1'b0, 16'h0000);
        wait_idle();
        check("zero_add", score[0], 32'h0042);
        check("zero_el",  el0_cnt - snap0, 32'd0);

        // Test 2: P1 crosses 1000
        push(1'b1, 16'h0995);
        wait_idle();
        check("t2_pre", score[1], 32'h0995);
        snap0 = el0_cnt;
        snap1 = el1_cnt;
        push(1'b1, 16'h0010);
        wait_idle();
        repeat (2) @(negedge clk);
        check("t2_score", score[1], 32'h1005);
        check("t2_el1",   el1_cnt - snap1, 32'd1);
        check("t2_el0",   el0_cnt - snap0, 32'd0);
        check("t2_p0",    score[0], 32'h0042);
        check("t2_hi",    hi_score, 32'h1005);

        // Test 3: multi-threshold jump then saturation
        snap0 = el0_cnt;
        push(1'b0, 16'h9948);
        wait_idle();
        repeat (2) @(negedge clk);
        check("t3_9990",  score[0], 32'h9990);
        check("t3_el_jump", el0_cnt - snap0, 32'd1);
        snap0 = el0_cnt;
        push(1'b0, 16'h0020);
        wait_idle();
        check("t3_sat",   score[0], 32'h9999);
        push(1'b0, 16'h0001);
        wait_idle();
        repeat (2) @(negedge clk);
        check("t3_hold",  score[0], 32'h9999);
        check("t3_el_sat", el0_cnt - snap0, 32'd0);
        check("t3_hi",    hi_score, 32'h9999);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_score", score, 32'h0000_0000);
        check("clr_hi",    hi_score, 32'h9999);

        // Test 4: hold add_valid for 8 cycles while the adder is busy
        burst_v = '{16'h0001, 16'h0010, 16'h0100, 16'h0002,
                    16'h3000, 16'h3000, 16'h3000, 16'h0200};
        push(1'b0, 16'h0001);
        for (int k = 0; k < 8; k++) begin
            add_valid  = 1'b1;
            add_player = 1'b1;
            add_value  = burst_v[k];
            burst_r[k] = add_ready;
            @(negedge clk);
        end
        add_valid = 1'b0;
        check("t4_rdy_pat", {24'd0, burst_r[7], burst_r[6], burst_r[5], burst_r[4],
                             burst_r[3], burst_r[2], burst_r[1], burst_r[0]}, 32'h8F);
        wait_idle();
        check("t4_p1",  score[1], 32'h0313);
        check("t4_p0",  score[0], 32'h0001);

        // Test 5: clear during ADD with three entries queued
        clr_v = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
        snap0 = el0_cnt;
        snap1 = el1_cnt;
        for (int k = 0; k < 4; k++) begin
            add_valid  = 1'b1;
            add_player = 1'b0;
            add_value  = clr_v[k];
            @(negedge clk);
        end
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        add_value = 16'h0500;
        clear     = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        add_valid = 1'b0;
        check("t5_score", score, 32'h0000_0000);
        check("t5_busy",  {31'd0, busy}, 32'd0);
        check("t5_ready", {31'd0, add_ready}, 32'd1);
        check("t5_hi",    hi_score, 32'h9999);
        repeat (10) @(negedge clk);
        check("t5_still0", score, 32'h0000_0000);
        check("t5_el",    (el0_cnt - snap0) + (el1_cnt - snap1), 32'd0);

        // Test 6: digit clamp, then async reset mid-ADD
        push(1'b0, 16'h000C);
        wait_idle();
        check("t6_clamp", score[0], 32'h0009);
        push(1'b1, 16'h0005);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        check("t6_score", score, 32'h0000_0000);
        check("t6_hi",    hi_score, 32'h0000);
        check("t6_busy",  {31'd0, busy}, 32'd0);
        check("t6_ready", {31'd0, add_ready}, 32'd1);
        check("t6_extra", {30'd0, extra_life}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
